// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester round-robin front end for a shared, purely combinational
// 4-bit ALU. One operation is in flight at a time:
//   IDLE : grant one requester, latch its operands/opcode
//   EXEC : the ALU result is valid, capture it into the granted response
//   RESP : hold the response until the granted requester acknowledges
// Optional feature: define ALU_ARB_OVF_CNT_EN to add the saturating
// Ovf_Count output that counts captured (masked) overflows.

module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       Req0_Valid,
  input  logic [3:0] Req0_In1,
  input  logic [3:0] Req0_In2,
  input  logic [1:0] Req0_Op,
  output logic       Req0_Ready,

  input  logic       Req1_Valid,
  input  logic [3:0] Req1_In1,
  input  logic [3:0] Req1_In2,
  input  logic [1:0] Req1_Op,
  output logic       Req1_Ready,

  output logic       Rsp0_Valid,
  output logic [3:0] Rsp0_Data,
  output logic       Rsp0_Error,
  input  logic       Rsp0_Ack,

  output logic       Rsp1_Valid,
  output logic [3:0] Rsp1_Data,
  output logic       Rsp1_Error,
  input  logic       Rsp1_Ack,

  output logic [3:0] ALU_In1,
  output logic [3:0] ALU_In2,
  output logic [1:0] Opcode,
  input  logic [3:0] ALU_Out,
  input  logic       Error
`ifdef ALU_ARB_OVF_CNT_EN
  ,
  output logic [3:0] Ovf_Count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;

  // ptr_q names the requester that wins when both are valid
  logic       ptr_q, ptr_d;
  // gnt_q remembers which requester owns the in-flight operation
  logic       gnt_q, gnt_d;

  logic [3:0] in1_q, in1_d;
  logic [3:0] in2_q, in2_d;
  logic [1:0] op_q, op_d;

  logic       rsp0_valid_q, rsp0_valid_d;
  logic [3:0] rsp0_data_q, rsp0_data_d;
  logic       rsp0_err_q, rsp0_err_d;

  logic       rsp1_valid_q, rsp1_valid_d;
  logic [3:0] rsp1_data_q, rsp1_data_d;
  logic       rsp1_err_q, rsp1_err_d;

`ifdef ALU_ARB_OVF_CNT_EN
  logic [3:0] ovf_cnt_q, ovf_cnt_d;
`endif

  logic       any_req;
  logic       gnt_id;
  logic       masked_err;
  logic       resp_ack;

  // Round-robin choice: the pointer only matters when both requesters are valid
  always_comb begin
    any_req = Req0_Valid | Req1_Valid;
    gnt_id  = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
      gnt_id = ptr_q;
    end else if (Req1_Valid) begin
      gnt_id = 1'b1;
    end
  end

  // Ready is combinational so the grant is visible in the same IDLE cycle; held low during reset
  always_comb begin
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      Req0_Ready = Req0_Valid & ~gnt_id;
      Req1_Ready = Req1_Valid &  gnt_id;
    end
  end

  // Overflow is meaningless for the logic ops, so it is masked by the opcode's upper bit
  always_comb begin
    masked_err = Error & ~op_q[1];
    resp_ack   = gnt_q ? Rsp1_Ack : Rsp0_Ack;
  end

  // Next-state and next-register values for the whole FSM datapath
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    op_d         = op_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_err_d   = rsp1_err_q;
`ifdef ALU_ARB_OVF_CNT_EN
    ovf_cnt_d    = ovf_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = gnt_id;
          in1_d   = gnt_id ? Req1_In1 : Req0_In1;
          in2_d   = gnt_id ? Req1_In2 : Req0_In2;
          op_d    = gnt_id ? Req1_Op  : Req0_Op;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = ALU_Out;
          rsp1_err_d   = masked_err;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = ALU_Out;
          rsp0_err_d   = masked_err;
        end
`ifdef ALU_ARB_OVF_CNT_EN
        if (masked_err && (ovf_cnt_q != 4'hF)) begin
          ovf_cnt_d = ovf_cnt_q + 4'd1;
        end
`endif
        state_d = RESP;
      end

      RESP: begin
        if (resp_ack) begin
          if (gnt_q) begin
            rsp1_valid_d = 1'b0;
          end else begin
            rsp0_valid_d = 1'b0;
          end
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register; reset discards any in-flight operation immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      in1_q        <= 4'd0;
      in2_q        <= 4'd0;
      op_q         <= 2'd0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= 4'd0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= 4'd0;
      rsp1_err_q   <= 1'b0;
`ifdef ALU_ARB_OVF_CNT_EN
      ovf_cnt_q    <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      op_q         <= op_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_err_q   <= rsp1_err_d;
`ifdef ALU_ARB_OVF_CNT_EN
      ovf_cnt_q    <= ovf_cnt_d;
`endif
    end
  end

  assign ALU_In1    = in1_q;
  assign ALU_In2    = in2_q;
  assign Opcode     = op_q;

  assign Rsp0_Valid = rsp0_valid_q;
  assign Rsp0_Data  = rsp0_data_q;
  assign Rsp0_Error = rsp0_err_q;
  assign Rsp1_Valid = rsp1_valid_q;
  assign Rsp1_Data  = rsp1_data_q;
  assign Rsp1_Error = rsp1_err_q;

`ifdef ALU_ARB_OVF_CNT_EN
  assign Ovf_Count  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter. A small combinational model stands in for
// the shared ALU; its error output can be forced high to show the masking on
// logic ops. Ovf_Count is connected and checked only when ALU_ARB_OVF_CNT_EN
// is defined.

module tb_alu_arbiter;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;

  logic       clk;
  logic       rst_n;

  logic       req0_valid, req1_valid;
  logic [3:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [1:0] req0_op, req1_op;
  logic       req0_ready, req1_ready;

  logic       rsp0_valid, rsp1_valid;
  logic [3:0] rsp0_data, rsp1_data;
  logic       rsp0_error, rsp1_error;
  logic       rsp0_ack, rsp1_ack;

  logic [3:0] alu_in1, alu_in2, alu_out;
  logic [1:0] opcode;
  logic       alu_err;
  logic       force_err;

`ifdef ALU_ARB_OVF_CNT_EN
  logic [3:0] ovf_count;
`endif

  int n_compared;
  int n_mismatched;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Req0_Valid (req0_valid),
    .Req0_In1   (req0_in1),
    .Req0_In2   (req0_in2),
    .Req0_Op    (req0_op),
    .Req0_Ready (req0_ready),
    .Req1_Valid (req1_valid),
    .Req1_In1   (req1_in1),
    .Req1_In2   (req1_in2),
    .Req1_Op    (req1_op),
    .Req1_Ready (req1_ready),
    .Rsp0_Valid (rsp0_valid),
    .Rsp0_Data  (rsp0_data),
    .Rsp0_Error (rsp0_error),
    .Rsp0_Ack   (rsp0_ack),
    .Rsp1_Valid (rsp1_valid),
    .Rsp1_Data  (rsp1_data),
    .Rsp1_Error (rsp1_error),
    .Rsp1_Ack   (rsp1_ack),
    .ALU_In1    (alu_in1),
    .ALU_In2    (alu_in2),
    .Opcode     (opcode),
    .ALU_Out    (alu_out),
    .Error      (alu_err)
`ifdef ALU_ARB_OVF_CNT_EN
    ,
    .Ovf_Count  (ovf_count)
`endif
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: two's-complement add/sub with signed overflow, plain logic ops
  always_comb begin
    alu_out = 4'd0;
    alu_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_out = alu_in1 + alu_in2;
        alu_err = (alu_in1[3] == alu_in2[3]) && (alu_out[3] != alu_in1[3]);
      end
      OP_SUB: begin
        alu_out = alu_in1 - alu_in2;
        alu_err = (alu_in1[3] != alu_in2[3]) && (alu_out[3] != alu_in1[3]);
      end
      OP_NAND: alu_out = ~(alu_in1 & alu_in2);
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
    if (force_err) alu_err = 1'b1;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic who, input logic [1:0] op,
                               input logic [3:0] a, input logic [3:0] b);
    if (!who) begin
      req0_valid = 1'b1; req0_op = op; req0_in1 = a; req0_in2 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_in1 = a; req1_in2 = b;
    end
  endtask

  task automatic clearInputs();
    req0_valid = 1'b0; req0_in1 = 4'd0; req0_in2 = 4'd0; req0_op = 2'd0;
    req1_valid = 1'b0; req1_in1 = 4'd0; req1_in2 = 4'd0; req1_op = 2'd0;
    rsp0_ack   = 1'b0; rsp1_ack = 1'b0;
    force_err  = 1'b0;
  endtask

  // Reset for two cycles, release on a falling edge
  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction starting in IDLE at a falling edge; ends at a falling edge back in IDLE
  task automatic doTxn(input logic who, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] exp_d, input logic exp_e,
                       input int hold, input string tag);
    applyStimulus(who, op, a, b);
    #1;
    checkOutput({tag, "_ready"}, 4'(who ? req1_ready : req0_ready), 4'd1);
    checkOutput({tag, "_other_ready"}, 4'(who ? req0_ready : req1_ready), 4'd0);
    @(posedge clk);
    @(negedge clk);
    if (!who) req0_valid = 1'b0; else req1_valid = 1'b0;
    checkOutput({tag, "_alu_in1"}, alu_in1, a);
    checkOutput({tag, "_alu_in2"}, alu_in2, b);
    checkOutput({tag, "_opcode"}, 4'(opcode), 4'(op));
    checkOutput({tag, "_valid_exec"}, 4'(who ? rsp1_valid : rsp0_valid), 4'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 4'(who ? rsp1_valid : rsp0_valid), 4'd1);
    checkOutput({tag, "_data"}, who ? rsp1_data : rsp0_data, exp_d);
    checkOutput({tag, "_error"}, 4'(who ? rsp1_error : rsp0_error), 4'(exp_e));
    for (int i = 0; i < hold; i++) begin
      if (!who) rsp1_ack = 1'b1; else rsp0_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp0_ack = 1'b0; rsp1_ack = 1'b0;
      checkOutput({tag, "_hold_valid"}, 4'(who ? rsp1_valid : rsp0_valid), 4'd1);
      checkOutput({tag, "_hold_data"}, who ? rsp1_data : rsp0_data, exp_d);
    end
    if (!who) rsp0_ack = 1'b1; else rsp1_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ack = 1'b0; rsp1_ack = 1'b0;
    checkOutput({tag, "_valid_after_ack"}, 4'(who ? rsp1_valid : rsp0_valid), 4'd0);
  endtask

  int       grant_cnt;
  logic     both_high;
  int       grant_who[4];
  int       grant_cyc[4];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clearInputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state, with a request pending to show Ready is held low
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    checkOutput("rst_ready0", 4'(req0_ready), 4'd0);
    checkOutput("rst_rsp0_valid", 4'(rsp0_valid), 4'd0);
    checkOutput("rst_rsp1_valid", 4'(rsp1_valid), 4'd0);
    checkOutput("rst_rsp0_data", rsp0_data, 4'd0);
    checkOutput("rst_alu_in1", alu_in1, 4'd0);
    checkOutput("rst_opcode", 4'(opcode), 4'd0);
`ifdef ALU_ARB_OVF_CNT_EN
    checkOutput("rst_ovf_count", ovf_count, 4'd0);
`endif
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operations on each requester
    doTxn(1'b0, OP_ADD,  4'h3, 4'h4, 4'h7, 1'b0, 2, "add_3_4");
    doTxn(1'b1, OP_SUB,  4'h1, 4'h8, 4'h9, 1'b1, 1, "sub_1_m8");
    checkOutput("rsp0_kept_data", rsp0_data, 4'h7);
    checkOutput("rsp0_kept_valid", 4'(rsp0_valid), 4'd0);
    doTxn(1'b0, OP_NAND, 4'hF, 4'hF, 4'h0, 1'b0, 0, "nand_f_f");
    force_err = 1'b1;
    doTxn(1'b1, OP_XOR,  4'h7, 4'h8, 4'hF, 1'b0, 0, "xor_7_8_forced");
    force_err = 1'b0;

    // A request raised during EXEC/RESP waits, then is withdrawn without effect
    applyStimulus(1'b0, OP_ADD, 4'h1, 4'h2);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    applyStimulus(1'b1, OP_SUB, 4'h5, 4'h5);
    #1;
    checkOutput("cancel_ready1_exec", 4'(req1_ready), 4'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("cancel_ready1_resp", 4'(req1_ready), 4'd0);
    checkOutput("cancel_rsp0_data", rsp0_data, 4'h3);
    req1_valid = 1'b0;
    rsp0_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("cancel_rsp1_valid", 4'(rsp1_valid), 4'd0);
    checkOutput("cancel_alu_in1", alu_in1, 4'h1);

    // Both requesters valid from reset with immediate acks: grants alternate every 3 cycles
    clearInputs();
    rst_n = 1'b0;
    applyStimulus(1'b0, OP_ADD, 4'h1, 4'h1);
    applyStimulus(1'b1, OP_XOR, 4'h5, 4'h3);
    rsp0_ack = 1'b1;
    rsp1_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    grant_cnt = 0;
    both_high = 1'b0;
    for (int cyc = 0; cyc < 40 && grant_cnt < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) both_high = 1'b1;
      if (req0_ready || req1_ready) begin
        grant_who[grant_cnt] = req1_ready ? 1 : 0;
        grant_cyc[grant_cnt] = cyc;
        grant_cnt++;
      end
      @(negedge clk);
    end
    checkOutput("rr_grant_count", 4'(grant_cnt), 4'd4);
    checkOutput("rr_both_ready", 4'(both_high), 4'd0);
    for (int g = 0; g < 4; g++) begin
      if (g < grant_cnt) begin
        checkOutput($sformatf("rr_grant%0d_who", g), 4'(grant_who[g]), 4'(g % 2));
        checkOutput($sformatf("rr_grant%0d_cycle", g), 4'(grant_cyc[g]), 4'(3 * g));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    rsp0_ack = 1'b0;
    rsp1_ack = 1'b0;
    checkOutput("rr_rsp0_data", rsp0_data, 4'h2);
    checkOutput("rr_rsp1_data", rsp1_data, 4'h6);

    // Reset while the response is held: cleared at once, nothing reappears afterwards
    clearInputs();
    applyStimulus(1'b0, OP_ADD, 4'h2, 4'h2);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_valid_before", 4'(rsp0_valid), 4'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 4'(rsp0_valid), 4'd0);
    checkOutput("mid_rst_data", rsp0_data, 4'd0);
    checkOutput("mid_rst_alu_in1", alu_in1, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_rst_valid0", 4'(rsp0_valid), 4'd0);
    checkOutput("post_rst_valid1", 4'(rsp1_valid), 4'd0);

    // Repeated overflowing ADD 7,1; the optional counter saturates at 15
    for (int k = 1; k <= 17; k++) begin
      doTxn(1'b0, OP_ADD, 4'h7, 4'h1, 4'h8, 1'b1, 0, $sformatf("ovf%0d", k));
`ifdef ALU_ARB_OVF_CNT_EN
      checkOutput($sformatf("ovf_count%0d", k), ovf_count, (k > 15) ? 4'd15 : 4'(k));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
